// File: rtl/spi_xfer_ctrl.sv
// Transfer sequencer for spi_shift: takes one command per transfer, paces SCLK from a
// programmable divider, frames the slave selects with guard times and returns the RX byte.
module spi_xfer_ctrl #(
  parameter int DIV_W = 8,
  parameter int SS_W  = 4
) (
  input  logic             wb_clk,
  input  logic             wb_reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_data,
  input  logic [2:0]       cmd_len,
  input  logic             cmd_lsb,
  input  logic             cmd_cpol,
  input  logic             cmd_cpha,
  input  logic [SS_W-1:0]  cmd_ss,
  input  logic [DIV_W-1:0] divider,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic             busy,
  output logic [SS_W-1:0]  ss_n,
  output logic             sh_go,
  output logic [2:0]       sh_len,
  output logic             sh_lsb,
  output logic             sh_tx_negedge,
  output logic             sh_rx_negedge,
  output logic [7:0]       sh_p_in,
  output logic [3:0]       sh_latch,
  output logic [3:0]       sh_byte_sel,
  output logic             sh_sclk,
  output logic             sh_pos_edge,
  output logic             sh_neg_edge,
  input  logic [7:0]       sh_p_out
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETUP, S_RUN, S_HOLD, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d;
  logic [4:0]       edge_cnt_q, edge_cnt_d, n2;
  logic [SS_W-1:0]  ss_q, ss_d, ss_n_q, ss_n_d;
  logic [2:0]       len_q, len_d;
  logic             lsb_q, lsb_d, rx_neg_q, rx_neg_d, tx_neg_q, tx_neg_d;
  logic [7:0]       p_in_q, p_in_d, rsp_data_q, rsp_data_d;
  logic [3:0]       latch_q, latch_d, byte_sel_q, byte_sel_d;
  logic             sclk_q, sclk_d, pos_q, pos_d, neg_q, neg_d, go_q, go_d;
  logic             cmd_ready_q, cmd_ready_d, busy_q, busy_d, rsp_valid_q, rsp_valid_d;

  // Both channels are strict valid/ready: a transfer happens only in a cycle where
  // valid && ready at the clock edge; the offering side holds its payload until then.
  assign n2 = (len_q == 3'd0) ? 5'd16 : {1'b0, len_q, 1'b0};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    edge_cnt_d  = edge_cnt_q;
    ss_d        = ss_q;
    ss_n_d      = ss_n_q;
    len_d       = len_q;
    lsb_d       = lsb_q;
    rx_neg_d    = rx_neg_q;
    tx_neg_d    = tx_neg_q;
    p_in_d      = p_in_q;
    rsp_data_d  = rsp_data_q;
    byte_sel_d  = byte_sel_q;
    sclk_d      = sclk_q;
    rsp_valid_d = rsp_valid_q;
    latch_d     = 4'b0000;
    pos_d       = 1'b0;
    neg_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          state_d    = S_LOAD;
          div_d      = divider;
          ss_d       = cmd_ss;
          len_d      = cmd_len;
          lsb_d      = cmd_lsb;
          rx_neg_d   = cmd_cpol ^ cmd_cpha;
          tx_neg_d   = ~(cmd_cpol ^ cmd_cpha);
          p_in_d     = cmd_data;
          latch_d    = 4'b0001;
          byte_sel_d = 4'b0001;
          sclk_d     = cmd_cpol;
          edge_cnt_d = 5'd0;
        end
      end
      S_LOAD: begin
        state_d = S_SETUP;
        cnt_d   = div_q;
        ss_n_d  = ~ss_q;
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_RUN;
          cnt_d   = div_q;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      S_RUN: begin
        // edge_cnt_q already includes the edge shown this cycle
        if (edge_cnt_q == n2) begin
          state_d = S_HOLD;
          cnt_d   = div_q;
        end else begin
          cnt_d = (cnt_q == '0) ? div_q : cnt_q - DIV_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == div_q) rsp_data_d = sh_p_out;
        if (cnt_q == '0) begin
          state_d     = S_DONE;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      S_DONE: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Strobes and SCLK are registered, so the edge decision looks at next-cycle state.
    if (state_d == S_RUN && cnt_d == '0) begin
      sclk_d     = ~sclk_q;
      pos_d      = ~sclk_q;
      neg_d      = sclk_q;
      edge_cnt_d = edge_cnt_q + 5'd1;
    end
    if (state_d == S_HOLD && cnt_d == '0) ss_n_d = '1;
    go_d        = (state_d == S_RUN);
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      div_q       <= '0;
      edge_cnt_q  <= 5'd0;
      ss_q        <= '0;
      ss_n_q      <= '1;
      len_q       <= 3'd0;
      lsb_q       <= 1'b0;
      rx_neg_q    <= 1'b0;
      tx_neg_q    <= 1'b1;
      p_in_q      <= 8'd0;
      rsp_data_q  <= 8'd0;
      latch_q     <= 4'b0000;
      byte_sel_q  <= 4'b0000;
      sclk_q      <= 1'b0;
      pos_q       <= 1'b0;
      neg_q       <= 1'b0;
      go_q        <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      edge_cnt_q  <= edge_cnt_d;
      ss_q        <= ss_d;
      ss_n_q      <= ss_n_d;
      len_q       <= len_d;
      lsb_q       <= lsb_d;
      rx_neg_q    <= rx_neg_d;
      tx_neg_q    <= tx_neg_d;
      p_in_q      <= p_in_d;
      rsp_data_q  <= rsp_data_d;
      latch_q     <= latch_d;
      byte_sel_q  <= byte_sel_d;
      sclk_q      <= sclk_d;
      pos_q       <= pos_d;
      neg_q       <= neg_d;
      go_q        <= go_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign busy          = busy_q;
  assign ss_n          = ss_n_q;
  assign sh_go         = go_q;
  assign sh_len        = len_q;
  assign sh_lsb        = lsb_q;
  assign sh_tx_negedge = tx_neg_q;
  assign sh_rx_negedge = rx_neg_q;
  assign sh_p_in       = p_in_q;
  assign sh_latch      = latch_q;
  assign sh_byte_sel   = byte_sel_q;
  assign sh_sclk       = sclk_q;
  assign sh_pos_edge   = pos_q;
  assign sh_neg_edge   = neg_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl: cycle-exact SCLK/strobe/select timing, reset,
// backpressure, mid-transfer divider change and back-to-back commands.
module tb_spi_xfer_ctrl;
  localparam int DIV_W = 8;
  localparam int SS_W  = 4;

  logic             wb_clk = 1'b0;
  logic             wb_reset;
  logic             cmd_valid, cmd_ready;
  logic [7:0]       cmd_data;
  logic [2:0]       cmd_len;
  logic             cmd_lsb, cmd_cpol, cmd_cpha;
  logic [SS_W-1:0]  cmd_ss;
  logic [DIV_W-1:0] divider;
  logic             rsp_valid, rsp_ready;
  logic [7:0]       rsp_data;
  logic             busy;
  logic [SS_W-1:0]  ss_n;
  logic             sh_go, sh_lsb, sh_tx_negedge, sh_rx_negedge;
  logic [2:0]       sh_len;
  logic [7:0]       sh_p_in, sh_p_out;
  logic [3:0]       sh_latch, sh_byte_sel;
  logic             sh_sclk, sh_pos_edge, sh_neg_edge;

  int checks = 0;
  int errors = 0;

  always #5 wb_clk = ~wb_clk;

  spi_xfer_ctrl #(.DIV_W(DIV_W), .SS_W(SS_W)) dut (
    .wb_clk(wb_clk), .wb_reset(wb_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data), .cmd_len(cmd_len),
    .cmd_lsb(cmd_lsb), .cmd_cpol(cmd_cpol), .cmd_cpha(cmd_cpha), .cmd_ss(cmd_ss),
    .divider(divider), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .ss_n(ss_n), .sh_go(sh_go), .sh_len(sh_len), .sh_lsb(sh_lsb),
    .sh_tx_negedge(sh_tx_negedge), .sh_rx_negedge(sh_rx_negedge), .sh_p_in(sh_p_in),
    .sh_latch(sh_latch), .sh_byte_sel(sh_byte_sel), .sh_sclk(sh_sclk),
    .sh_pos_edge(sh_pos_edge), .sh_neg_edge(sh_neg_edge), .sh_p_out(sh_p_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One cycle forward; outputs are then stable and inputs set here are sampled next edge.
  task automatic step();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic chk_reset_state();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'(1));
    chk("rst_busy",      32'(busy),      32'(0));
    chk("rst_ss_n",      32'(ss_n),      32'(4'hF));
    chk("rst_sclk",      32'(sh_sclk),   32'(0));
    chk("rst_pos",       32'(sh_pos_edge), 32'(0));
    chk("rst_neg",       32'(sh_neg_edge), 32'(0));
    chk("rst_go",        32'(sh_go),     32'(0));
    chk("rst_latch",     32'(sh_latch),  32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_rsp_data",  32'(rsp_data),  32'(0));
  endtask

  task automatic chk_idle(input logic exp_sclk);
    chk("idle_cmd_ready", 32'(cmd_ready), 32'(1));
    chk("idle_busy",      32'(busy),      32'(0));
    chk("idle_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("idle_ss_n",      32'(ss_n),      32'(4'hF));
    chk("idle_sclk",      32'(sh_sclk),   32'(exp_sclk));
  endtask

  // Offer a command in the current (IDLE) cycle, then check the LOAD cycle.
  task automatic issue(input logic [7:0] data, input logic [2:0] len, input logic lsb,
                       input logic cpol, input logic cpha, input logic [3:0] ss,
                       input logic [7:0] div, input bit keep);
    logic exp_rx, exp_tx;
    exp_rx = cpol ^ cpha;
    exp_tx = ~exp_rx;
    cmd_data = data; cmd_len = len; cmd_lsb = lsb; cmd_cpol = cpol; cmd_cpha = cpha;
    cmd_ss = ss; divider = div; cmd_valid = 1'b1;
    chk("issue_cmd_ready", 32'(cmd_ready), 32'(1));
    step();
    if (!keep) cmd_valid = 1'b0;
    chk("load_latch",     32'(sh_latch),      32'(4'b0001));
    chk("load_byte_sel",  32'(sh_byte_sel),   32'(4'b0001));
    chk("load_p_in",      32'(sh_p_in),       32'(data));
    chk("load_sclk",      32'(sh_sclk),       32'(cpol));
    chk("load_len",       32'(sh_len),        32'(len));
    chk("load_lsb",       32'(sh_lsb),        32'(lsb));
    chk("load_rx_negedge", 32'(sh_rx_negedge), 32'(exp_rx));
    chk("load_tx_negedge", 32'(sh_tx_negedge), 32'(exp_tx));
    chk("load_busy",      32'(busy),          32'(1));
    chk("load_cmd_ready", 32'(cmd_ready),     32'(0));
    chk("load_ss_n",      32'(ss_n),          32'(4'hF));
    chk("load_go",        32'(sh_go),         32'(0));
  endtask

  // Walk cycles T+2 .. first rsp_valid cycle, checking against the closed-form timing:
  // h = d+1, edges at T+1+2h + k*h, last edge T+1+h+2nh, rsp_valid at T+2+2h+2nh.
  task automatic check_xfer(input int d, input int n, input logic cpol, input logic [3:0] ss,
                            input logic [7:0] rx, input int chg_c, input logic [7:0] chg_div);
    int h, first, last, vc, so_far, nedge;
    logic exp_edge, exp_sclk, exp_pos, exp_neg, exp_go, exp_rv;
    logic [3:0] ss_on, exp_ssn;
    h = d + 1; first = 1 + 2*h; last = 1 + h + 2*n*h; vc = last + h + 1;
    ss_on = ~ss;
    nedge = 0;
    for (int c = 2; c <= vc; c++) begin
      step();
      sh_p_out = (c == last + 1) ? rx : ~rx;
      if (c == chg_c) divider = chg_div;
      exp_edge = (c >= first) && (c <= last) && (((c - first) % h) == 0);
      if (c < first) so_far = 0;
      else so_far = ((c - first) / h + 1 > 2*n) ? 2*n : (c - first) / h + 1;
      exp_sclk = cpol ^ so_far[0];
      exp_pos  = exp_edge && exp_sclk;
      exp_neg  = exp_edge && !exp_sclk;
      exp_go   = (c >= 2 + h) && (c <= last);
      exp_ssn  = (c <= last + h - 1) ? ss_on : 4'hF;
      exp_rv   = (c == vc);
      chk("xfer_pos_edge",  32'(sh_pos_edge), 32'(exp_pos));
      chk("xfer_neg_edge",  32'(sh_neg_edge), 32'(exp_neg));
      chk("xfer_sclk",      32'(sh_sclk),     32'(exp_sclk));
      chk("xfer_go",        32'(sh_go),       32'(exp_go));
      chk("xfer_ss_n",      32'(ss_n),        32'(exp_ssn));
      chk("xfer_rsp_valid", 32'(rsp_valid),   32'(exp_rv));
      chk("xfer_busy",      32'(busy),        32'(1));
      chk("xfer_cmd_ready", 32'(cmd_ready),   32'(0));
      nedge += int'(sh_pos_edge) + int'(sh_neg_edge);
    end
    chk("xfer_edge_count", 32'(nedge), 32'(2*n));
    chk("xfer_rsp_data",   32'(rsp_data), 32'(rx));
  endtask

  initial begin
    int npos, nneg;
    wb_reset = 1'b0; cmd_valid = 1'b0; cmd_data = '0; cmd_len = '0; cmd_lsb = 1'b0;
    cmd_cpol = 1'b0; cmd_cpha = 1'b0; cmd_ss = '0; divider = '0; rsp_ready = 1'b1;
    sh_p_out = '0;
    step();
    step();
    chk_reset_state();
    wb_reset = 1'b1;
    step();

    // Mode 0, D=1, 4 bits, single slave
    issue(8'hAD, 3'd4, 1'b0, 1'b0, 1'b0, 4'b0001, 8'd1, 1'b0);
    check_xfer(1, 4, 1'b0, 4'b0001, 8'h3C, 0, 8'd0);
    step();
    chk_idle(1'b0);
    chk("idle_rsp_data_hold", 32'(rsp_data), 32'(8'h3C));

    // cpol=1 cpha=1, 8 bits, D=0, then 10 cycles of response backpressure
    rsp_ready = 1'b0;
    issue(8'hC3, 3'd0, 1'b1, 1'b1, 1'b1, 4'b0110, 8'd0, 1'b0);
    check_xfer(0, 8, 1'b1, 4'b0110, 8'h96, 0, 8'd0);
    for (int i = 0; i < 9; i++) begin
      step();
      sh_p_out = 8'h10 + 8'(i);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'(1));
      chk("bp_rsp_data",  32'(rsp_data),  32'(8'h96));
      chk("bp_cmd_ready", 32'(cmd_ready), 32'(0));
      chk("bp_busy",      32'(busy),      32'(1));
    end
    rsp_ready = 1'b1;
    step();
    chk_idle(1'b1);

    // Divider raised from 1 to 5 just after the first edge; no slave selected
    issue(8'h69, 3'd2, 1'b0, 1'b0, 1'b1, 4'b0000, 8'd1, 1'b0);
    check_xfer(1, 2, 1'b0, 4'b0000, 8'hA5, 6, 8'd5);
    step();
    chk_idle(1'b0);

    // Reset in RUN after the third edge, new command right after release
    issue(8'hF0, 3'd4, 1'b0, 1'b0, 1'b0, 4'b0010, 8'd1, 1'b0);
    npos = 0; nneg = 0;
    for (int c = 2; c <= 10; c++) begin
      step();
      npos += int'(sh_pos_edge);
      nneg += int'(sh_neg_edge);
    end
    chk("pre_rst_pos_count", 32'(npos), 32'(2));
    chk("pre_rst_neg_count", 32'(nneg), 32'(1));
    chk("pre_rst_sclk",      32'(sh_sclk), 32'(1));
    chk("pre_rst_ss_n",      32'(ss_n),    32'(4'b1101));
    wb_reset = 1'b0;
    step();
    chk_reset_state();
    wb_reset = 1'b1;
    issue(8'h3E, 3'd3, 1'b0, 1'b0, 1'b1, 4'b1111, 8'd0, 1'b0);
    check_xfer(0, 3, 1'b0, 4'b1111, 8'h81, 0, 8'd0);
    step();
    chk_idle(1'b0);

    // Back-to-back: cmd_valid stays high; fields switch to the second command mid-transfer
    issue(8'h12, 3'd1, 1'b0, 1'b0, 1'b0, 4'b0100, 8'd0, 1'b1);
    cmd_data = 8'hE7; cmd_len = 3'd2; cmd_cpol = 1'b1; cmd_cpha = 1'b0;
    cmd_ss = 4'b0001; divider = 8'd2;
    check_xfer(0, 1, 1'b0, 4'b0100, 8'h44, 0, 8'd0);
    step();
    issue(8'hE7, 3'd2, 1'b0, 1'b1, 1'b0, 4'b0001, 8'd2, 1'b0);
    check_xfer(2, 2, 1'b1, 4'b0001, 8'hC8, 0, 8'd0);
    step();
    chk_idle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_xfer_ctrl.md
Name: spi_xfer_ctrl

Overview:
Transfer sequencer for the spi_shift datapath. It accepts one command per transfer over a valid/ready handshake and loads the shifter's parallel input. It generates SCLK and the per-edge strobes from a programmable divider, drives the slave selects with setup and hold guard times, and returns the received byte over a valid/ready response. Sits between the Wishbone register block and spi_shift.

Parameters:
DIV_W, 8, width of divider input
SS_W, 4, number of slave-select lines

Ports:
wb_clk  in  1  system clock
wb_reset  in  1  synchronous reset, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
cmd_data  in  8  TX byte
cmd_len  in  3  bits to transfer; 0 means 8
cmd_lsb  in  1  LSB-first
cmd_cpol  in  1  SCLK idle level
cmd_cpha  in  1  clock phase
cmd_ss  in  SS_W  slaves to select, active-high mask
divider  in  DIV_W  SCLK half-period = divider+1 wb_clk cycles
rsp_valid  out  1  RX byte available
rsp_ready  in  1  RX byte consumed
rsp_data  out  8  RX byte
busy  out  1  high in every state except IDLE
ss_n  out  SS_W  slave selects, active-low
sh_go  out  1  shifter go
sh_len  out  3  to shifter len
sh_lsb  out  1  to shifter lsb
sh_tx_negedge  out  1  to shifter tx_negedge
sh_rx_negedge  out  1  to shifter rx_negedge
sh_p_in  out  8  to shifter p_in
sh_latch  out  4  to shifter latch
sh_byte_sel  out  4  to shifter byte_sel
sh_sclk  out  1  SCLK to shifter and pad
sh_pos_edge  out  1  one-cycle strobe on SCLK rise (shifter cpol_0)
sh_neg_edge  out  1  one-cycle strobe on SCLK fall (shifter cpol_1)
sh_p_out  in  8  shifter parallel output

Behaviour:
- Reset (wb_reset==0 at a wb_clk posedge) applies in any state, including mid-transfer.
  - FSM goes to IDLE.
  - ss_n = all ones; sh_sclk = 0; stored cpol = 0.
  - All strobes 0: sh_go, sh_latch, sh_pos_edge, sh_neg_edge, rsp_valid.
  - rsp_data = 0; busy = 0; the in-flight command is dropped.
- All outputs are registered.
- States:
  - IDLE: cmd_ready=1. On handshake, register all cmd_* fields and divider -> LOAD. cmd_ready=0 in every other state.
  - LOAD (1 cycle): sh_p_in = data; sh_latch = 4'b0001; sh_byte_sel = 4'b0001; sh_sclk = registered cpol -> SETUP.
  - SETUP (divider+1 cycles): ss_n = ~cmd_ss; SCLK idle -> RUN.
  - RUN: sh_go=1.
    - Half-period counter loads divider on entry and decrements each cycle.
    - At 0: toggle sh_sclk, pulse sh_pos_edge (0->1) or sh_neg_edge (1->0) in the same cycle, reload.
    - After 2*N edges (N = cmd_len, or 8 if cmd_len==0) -> HOLD. sh_sclk is then back at cpol.
  - HOLD (divider+1 cycles): ss_n held; sh_go=0.
    - First HOLD cycle captures sh_p_out into rsp_data.
    - Last HOLD cycle drives ss_n all ones -> DONE.
  - DONE: rsp_valid=1 until rsp_ready sampled high, then -> IDLE. rsp_data stable while rsp_valid.
- Mode mapping, fixed for the whole transfer:
  - sh_rx_negedge = cpol^cpha.
  - sh_tx_negedge = ~(cpol^cpha).
  - sh_len = cmd_len; sh_lsb = cmd_lsb.
- Timing (handshake at cycle T, divider = D, h = D+1):
  - LOAD at T+1.
  - SETUP T+2 .. T+1+h.
  - First edge at T+1+2h; edges spaced h cycles apart; last edge at T+1+h+2N*h.
  - rsp_valid first high at T+2+2h+2N*h.
- D=0: an edge every cycle; SETUP and HOLD are 1 cycle each.
- cmd_ss = 0: transfer runs normally; ss_n stays all ones.
- Multi-hot cmd_ss: all selected lines assert together.
- Changing divider or cmd_* fields while busy has no effect on the current transfer.
- The next command is accepted only in IDLE, i.e. after rsp_valid&&rsp_ready.

Test Plan:
- Mode 0, D=1, len=4, data=8'hAD, ss=4'b0001, rsp_ready=1. Handshake at T ->
  - latch at T+1; ss_n=4'b1110 from T+2.
  - Edges at T+5, T+7, ..., T+19; pos_edge on odd-numbered edges.
  - ss_n=4'b1111 at T+21; rsp_valid at T+22 with rsp_data = sh_p_out sampled at T+20.
- cpol=1, cpha=1, len=0 (8 bits), D=0 ->
  - SCLK idles 1 from LOAD; first strobe is sh_neg_edge.
  - 16 edges on consecutive cycles; rx_negedge=0, tx_negedge=1.
- Assert reset (wb_reset=0) during RUN after the 3rd edge -> next cycle:
  - IDLE; ss_n=4'b1111; sh_sclk=0; no strobes; busy=0; rsp_valid=0.
  - A new command is accepted the first cycle after release.
- Backpressure: hold rsp_ready=0 for 10 cycles in DONE ->
  - rsp_valid and rsp_data stable; cmd_ready=0 throughout.
  - Release -> IDLE next cycle; cmd_ready=1.
- Change divider from 1 to 5 mid-RUN -> edge spacing stays 2 cycles until the transfer completes.
- Back-to-back: cmd_valid held high with two commands, rsp_ready=1 -> the second is accepted exactly one cycle after the first response handshake.
